aes_encrypt_iter: RTL
=====================

# aes_encrypt_iter

Iterative AES-128 encryption core: one cipher round per clock, with the round key expanded on the fly alongside the state. It is the encrypt-direction counterpart of the unrolled decryption datapath and shares its byte ordering. Its output ciphertext must decrypt back to the original plaintext under the same key. Valid/ready handshakes sit on both input and output so the core drops into a streaming wrapper.

## Interface
- Nk, 4, key length in 32-bit words; only 4 is legal.
- Nr, 10, number of rounds; only 10 is legal.
- Nb, 4, block size in 32-bit columns; only 4 is legal.

- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  dataIn/keyIn hold a block to encrypt.
- in_ready  output  1  core can accept a block.
- dataIn  input  128  plaintext; [127:120] is byte 0 (row 0, col 0); column-major FIPS-197 order.
- keyIn  input  Nk*32  cipher key, same byte ordering.
- out_valid  output  1  dataOut holds a finished ciphertext.
- out_ready  input  1  downstream accepts dataOut.
- dataOut  output  128  ciphertext, same byte ordering.
- lastKeyOut  output  128  final round key w[40..43]; present only with AES_ENC_LAST_KEY_OUT_EN.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= dataIn ^ keyIn, rk_reg <= keyIn, round <= 1, go to ROUND.
- ROUND, round r = 1..10:
  - next_rk = KeyExpand(rk_reg, Rcon[r]); Rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
  - Rounds 1–9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_rk.
  - Round 10: same without MixColumns.
  - rk_reg <= next_rk each round; round increments.
  - After round 10 is written, go to DONE.
- DONE:
  - out_valid=1; dataOut = state_reg, held stable.
  - On out_ready, go to IDLE.
- in_ready is high only in IDLE. A block is never accepted in the same cycle as output handoff.
- in_valid/out_ready are ignored outside IDLE/DONE respectively. Input values are sampled only at the accepting edge, so dataIn/keyIn may change afterward.
- Round counter is 4 bits. Values 0 and 11–15 are unreachable; if reached, the FSM goes to IDLE.
- SubBytes and KeyExpand S-boxes are combinational lookup (16+4 instances). No multicycle paths.

## Timing
- Reset values:
  - FSM=IDLE, round=0.
  - state_reg=0, rk_reg=0, dataOut=0.
  - out_valid=0, in_ready=1 (first cycle after reset deasserts).
  - lastKeyOut=0.
- Latency:
  - Accept at edge E; rounds 1..10 are written at E+1..E+10.
  - out_valid is high from the cycle after E+10.
- Handoff and throughput:
  - Handoff at edge H (out_valid&&out_ready); in_ready is high from the cycle after H.
  - Minimum block period is 12 cycles with out_ready held high.
- Backpressure: out_ready low holds DONE indefinitely; dataOut and lastKeyOut remain stable.
- Reset mid-operation: in-flight block is discarded; all reset values apply at the next edge.
- Reset has priority over any simultaneous handshake.

## Configuration
- AES_ENC_LAST_KEY_OUT_EN:
  - Defined: port lastKeyOut exists and is registered with rk_reg after round 10, valid while out_valid=1. A paired decryptor can start from it without re-expanding the key.
  - Undefined: port and its register are absent; the rest of the behaviour is identical.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> dataOut 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after the accepting edge; with macro, lastKeyOut 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; with macro, lastKeyOut d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> dataOut stable, in_ready=0 throughout, and in_valid pulses are ignored. Release -> in_ready=1 the next cycle.
- Back-to-back: in_valid and out_ready tied high with the two vectors alternating -> correct ciphertexts every 12 cycles, with no dropped or duplicated blocks.
- Reset at round 5 -> next cycle out_valid=0, in_ready=1, dataOut=0. A fresh C.1 block then yields 69c4e0d8... unaffected.
- Round-trip: feed the C.1 ciphertext and key through the decryption datapath -> 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_encrypt_iter_if.sv
// Streaming handshake bundle for aes_encrypt_iter: input block/key with valid/ready and
// ciphertext output with valid/ready. The optional lastKeyOut signal exists only when
// AES_ENC_LAST_KEY_OUT_EN is defined.
interface aes_encrypt_iter_if #(
  parameter int unsigned Nk = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      dataIn;
  logic [Nk*32-1:0]  keyIn;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      dataOut;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [127:0]      lastKeyOut;
`endif

  // Upstream/downstream side (drives blocks in, consumes ciphertext)
  modport master (
`ifdef AES_ENC_LAST_KEY_OUT_EN
    input  lastKeyOut,
`endif
    output in_valid,
    output dataIn,
    output keyIn,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dataOut
  );

  // Core side
  modport slave (
`ifdef AES_ENC_LAST_KEY_OUT_EN
    output lastKeyOut,
`endif
    input  in_valid,
    input  dataIn,
    input  keyIn,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dataOut
  );
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock with the round key expanded on the fly.
// Byte 0 (row 0, col 0) sits in bits [127:120]; bytes run column-major as in FIPS-197.
// Optional feature macro: AES_ENC_LAST_KEY_OUT_EN adds the registered lastKeyOut output
// (round-10 key) so a paired decryptor can start without re-expanding the key.
module aes_encrypt_iter #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10,
  parameter int unsigned Nb = 4
) (
  input  logic              clk,
  input  logic              reset,
  aes_encrypt_iter_if.slave bus
);

  localparam int unsigned BlockW    = Nb * 32;
  localparam int unsigned KeyW      = Nk * 32;
  localparam logic [3:0]  LastRound = 4'(Nr);

  // Forward S-box, entry b at bits [2047-8b -: 8]
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r, c+r)
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      o[103 - 32 * c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One step of the AES-128 key schedule: four new words from the previous four
  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h000000};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        round_q, round_d;
  logic [BlockW-1:0] data_q, data_d;
  logic [KeyW-1:0]   rk_q, rk_d;
  logic [KeyW-1:0]   next_rk;
  logic [BlockW-1:0] sr_out;
  logic [BlockW-1:0] mc_out;

  // Round datapath: key schedule step and cipher round on the current registers
  always_comb begin
    next_rk = key_expand(rk_q, rcon_of(round_q));
    sr_out  = shift_rows(sub_bytes(data_q));
    mc_out  = mix_columns(sr_out);
  end

  // FSM next-state and register loads
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    rk_d    = rk_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.dataIn ^ bus.keyIn;
          rk_d    = bus.keyIn;
          round_d = 4'd1;
          state_d = StRound;
        end
      end
      StRound: begin
        if (round_q == 4'd0 || round_q > LastRound) begin
          // Corrupted counter: abandon the block
          round_d = 4'd0;
          state_d = StIdle;
        end else begin
          rk_d    = next_rk;
          data_d  = ((round_q == LastRound) ? sr_out : mc_out) ^ next_rk;
          round_d = round_q + 4'd1;
          if (round_q == LastRound) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        round_d = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      data_q  <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
      rk_q    <= rk_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.dataOut   = data_q;

`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [KeyW-1:0] last_key_q, last_key_d;

  // Capture the final round key alongside the last cipher round
  always_comb begin
    last_key_d = last_key_q;
    if (state_q == StRound && round_q == LastRound) begin
      last_key_d = next_rk;
    end
  end

  // Final round key register, held through DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      last_key_q <= '0;
    end else begin
      last_key_q <= last_key_d;
    end
  end

  assign bus.lastKeyOut = last_key_q;
`endif

endmodule
